// File: rtl/llki_gate_pkg.sv
// Shared types and helpers for the keyed stream gate: key-state encoding and
// the replication of the key difference across the data bus.
package llki_gate_pkg;

   typedef enum logic [1:0] {
      KS_LOCKED   = 2'd0,
      KS_LOADING  = 2'd1,
      KS_UNLOCKED = 2'd2,
      KS_CLEARING = 2'd3
   } key_state_e;

   // Widest supported data bus and key; both must stay below this.
   localparam int unsigned MASK_MAX_W = 4096;

   // Repeat the low diff_w bits of diff LSB-aligned across data_w bits; bits above data_w are zero.
   function automatic logic [MASK_MAX_W-1:0] replicate_diff(input logic [MASK_MAX_W-1:0] diff,
                                                           input int unsigned diff_w,
                                                           input int unsigned data_w);
      logic [MASK_MAX_W-1:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
         if (i < data_w) begin
            mask[i] = diff[i % diff_w];
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/llki_key_bank.sv
// Multi-word key bank with written mask, sequential zeroisation counter and the
// lock/load/unlock/clear state machine.
module llki_key_bank
   import llki_gate_pkg::*;
#(
   parameter int unsigned KEY_W                         = 64,
   parameter int unsigned KEY_WORDS                     = 2,
   parameter logic [KEY_WORDS*KEY_W-1:0] EXP_KEY        = '0,
   parameter int unsigned IDX_W                         = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_wr_valid,
   output logic                       o_wr_ready,
   input  logic [IDX_W-1:0]           i_wr_idx,
   input  logic [KEY_W-1:0]           i_wr_data,
   input  logic                       i_clear,
   output key_state_e                 o_state,
   output logic                       o_match,
   output logic [KEY_WORDS*KEY_W-1:0] o_bank
);

   localparam int unsigned KEY_TOT = KEY_WORDS * KEY_W;

   logic [KEY_TOT-1:0]   r_bank;
   logic [KEY_WORDS-1:0] r_written;
   logic [IDX_W-1:0]     r_clr_idx;
   key_state_e           r_state;
   logic                 r_match;

   logic [KEY_TOT-1:0]   w_bank_nxt;
   logic [KEY_WORDS-1:0] w_written_nxt;
   logic [IDX_W-1:0]     w_clr_idx_nxt;
   key_state_e           w_state_nxt;
   logic                 w_idx_ok;
   logic                 w_wr_en;

   assign o_wr_ready = (r_state != KS_CLEARING);
   // Out-of-range indices complete the handshake but are discarded.
   assign w_idx_ok   = (32'(i_wr_idx) < KEY_WORDS);
   assign w_wr_en    = i_wr_valid && o_wr_ready && w_idx_ok;

   always_comb begin
      w_bank_nxt    = r_bank;
      w_written_nxt = r_written;
      w_clr_idx_nxt = r_clr_idx;
      w_state_nxt   = r_state;
      if (i_clear) begin
         w_state_nxt   = KS_CLEARING;
         w_clr_idx_nxt = '0;
         w_written_nxt = '0;
      end else if (r_state == KS_CLEARING) begin
         // Word 0 sits in the MSBs of the packed bank.
         w_bank_nxt[(KEY_WORDS - 1 - 32'(r_clr_idx)) * KEY_W +: KEY_W] = '0;
         if (32'(r_clr_idx) == KEY_WORDS - 1) begin
            w_state_nxt = KS_LOCKED;
         end else begin
            w_clr_idx_nxt = r_clr_idx + 1'b1;
         end
      end else begin
         if (w_wr_en) begin
            w_bank_nxt[(KEY_WORDS - 1 - 32'(i_wr_idx)) * KEY_W +: KEY_W] = i_wr_data;
            w_written_nxt[i_wr_idx] = 1'b1;
         end
         unique case (r_state)
            KS_LOCKED:  if (w_wr_en) w_state_nxt = KS_LOADING;
            KS_LOADING: if (&w_written_nxt) w_state_nxt = KS_UNLOCKED;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bank    <= '0;
         r_written <= '0;
         r_clr_idx <= '0;
         r_state   <= KS_LOCKED;
         r_match   <= 1'b0;
      end else begin
         r_bank    <= w_bank_nxt;
         r_written <= w_written_nxt;
         r_clr_idx <= w_clr_idx_nxt;
         r_state   <= w_state_nxt;
         // Built from next-state values so match always agrees with state and bank.
         r_match   <= (w_state_nxt == KS_UNLOCKED) && (w_bank_nxt == EXP_KEY);
      end
   end

   assign o_state = r_state;
   assign o_match = r_match;
   assign o_bank  = r_bank;

endmodule

// File: rtl/llki_keyed_stream_gate.sv
// Keyed valid/ready register stage: data passes clean only with the expected key
// loaded, otherwise it is XOR-scrambled with the key difference.
module llki_keyed_stream_gate
   import llki_gate_pkg::*;
#(
   parameter int unsigned DATA_W                   = 512,
   parameter int unsigned KEY_W                    = 64,
   parameter int unsigned KEY_WORDS                = 2,
   parameter logic [KEY_WORDS*KEY_W-1:0] EXP_KEY   = '0,
   parameter int unsigned IDX_W                    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_key_wr_valid,
   output logic              o_key_wr_ready,
   input  logic [IDX_W-1:0]  i_key_wr_idx,
   input  logic [KEY_W-1:0]  i_key_wr_data,
   input  logic              i_key_clear,
   output logic [1:0]        o_key_state,
   output logic              o_key_match,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data
);

   localparam int unsigned KEY_TOT = KEY_WORDS * KEY_W;

   key_state_e            w_state;
   logic [KEY_TOT-1:0]    w_bank;
   logic [MASK_MAX_W-1:0] w_mask_full;
   logic [DATA_W-1:0]     w_mask;
   logic                  w_unused_mask;
   logic                  w_accept;

   logic                  r_out_valid;
   logic [DATA_W-1:0]     r_out_data;

   llki_key_bank #(
      .KEY_W     (KEY_W),
      .KEY_WORDS (KEY_WORDS),
      .EXP_KEY   (EXP_KEY),
      .IDX_W     (IDX_W)
   ) u_key_bank (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr_valid (i_key_wr_valid),
      .o_wr_ready (o_key_wr_ready),
      .i_wr_idx   (i_key_wr_idx),
      .i_wr_data  (i_key_wr_data),
      .i_clear    (i_key_clear),
      .o_state    (w_state),
      .o_match    (o_key_match),
      .o_bank     (w_bank)
   );

   assign w_mask_full   = replicate_diff(MASK_MAX_W'(w_bank ^ EXP_KEY), KEY_TOT, DATA_W);
   assign w_mask        = w_mask_full[DATA_W-1:0];
   assign w_unused_mask = ^w_mask_full[MASK_MAX_W-1:DATA_W];

   assign o_in_ready = (w_state == KS_UNLOCKED) && (!r_out_valid || i_out_ready);
   assign w_accept   = i_in_valid && o_in_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (i_key_clear) begin
         // Flush on clear so nothing scrambled or clean lingers past zeroisation.
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= i_in_data ^ w_mask;
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_key_state = w_state;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_llki_keyed_stream_gate.sv
// Randomised and directed bench for llki_keyed_stream_gate with a queue-based
// scoreboard fed from a behavioural key/stream model.
module tb_llki_keyed_stream_gate;

   localparam int DATA_W    = 512;
   localparam int KEY_W     = 64;
   localparam int KEY_WORDS = 2;
   localparam int IDX_W     = 1;
   localparam logic [KEY_W-1:0] W0 = 64'h0123456789ABCDEF;
   localparam logic [KEY_W-1:0] W1 = 64'hFEDCBA9876543210;
   localparam logic [127:0] EXP_KEY = {W0, W1};

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              key_wr_valid = 1'b0;
   logic              key_wr_ready;
   logic [IDX_W-1:0]  key_wr_idx = '0;
   logic [KEY_W-1:0]  key_wr_data = '0;
   logic              key_clear = 1'b0;
   logic [1:0]        key_state;
   logic              key_match;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   llki_keyed_stream_gate #(
      .DATA_W    (DATA_W),
      .KEY_W     (KEY_W),
      .KEY_WORDS (KEY_WORDS),
      .EXP_KEY   (EXP_KEY)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_key_wr_valid (key_wr_valid),
      .o_key_wr_ready (key_wr_ready),
      .i_key_wr_idx   (key_wr_idx),
      .i_key_wr_data  (key_wr_data),
      .i_key_clear    (key_clear),
      .o_key_state    (key_state),
      .o_key_match    (key_match),
      .i_in_valid     (in_valid),
      .o_in_ready     (in_ready),
      .i_in_data      (in_data),
      .o_out_valid    (out_valid),
      .i_out_ready    (out_ready),
      .o_out_data     (out_data)
   );

   // Reference model: key words, written flags, state number, clear progress.
   logic [KEY_W-1:0]  m_key [KEY_WORDS];
   bit                m_written [KEY_WORDS];
   int                m_state = 0;
   int                m_clr = 0;
   bit                m_started = 1'b0;
   logic [DATA_W-1:0] m_hold = '0;
   logic [DATA_W-1:0] sb_q [$];

   task automatic check(input string name, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] mask_of();
      logic [127:0] diff;
      logic [DATA_W-1:0] m;
      diff = {m_key[0], m_key[1]} ^ EXP_KEY;
      for (int i = 0; i < DATA_W; i++) m[i] = diff[i % 128];
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] rand512();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   always @(posedge clk) begin
      bit acc;
      acc = in_valid && (m_state == 2) && (sb_q.size() == 0);
      if (rst) begin
         for (int k = 0; k < KEY_WORDS; k++) begin
            m_key[k] = '0;
            m_written[k] = 1'b0;
         end
         m_state = 0;
         m_clr = 0;
         m_hold = '0;
         sb_q.delete();
      end else if (key_clear) begin
         for (int k = 0; k < KEY_WORDS; k++) m_written[k] = 1'b0;
         m_state = 3;
         m_clr = 0;
         m_hold = '0;
         sb_q.delete();
      end else begin
         if (acc) sb_q.push_back(in_data ^ mask_of());
         if (m_state == 3) begin
            m_key[m_clr] = '0;
            m_clr++;
            if (m_clr == KEY_WORDS) m_state = 0;
         end else if (key_wr_valid && int'(key_wr_idx) < KEY_WORDS) begin
            m_key[key_wr_idx] = key_wr_data;
            m_written[key_wr_idx] = 1'b1;
            if (m_state == 0) m_state = 1;
            else if (m_state == 1 && m_written[0] && m_written[1]) m_state = 2;
         end
      end
      m_started = 1'b1;
   end

   // Monitor: compares every output against the model and retires handshakes.
   always @(negedge clk) begin
      if (m_started) begin
         check("key_state", DATA_W'(key_state), DATA_W'(m_state));
         check("key_wr_ready", DATA_W'(key_wr_ready), DATA_W'(m_state != 3));
         check("key_match", DATA_W'(key_match),
               DATA_W'(m_state == 2 && {m_key[0], m_key[1]} == EXP_KEY));
         check("in_ready", DATA_W'(in_ready),
               DATA_W'(m_state == 2 && (sb_q.size() == 0 || out_ready)));
         check("out_valid", DATA_W'(out_valid), DATA_W'(sb_q.size() != 0));
         if (sb_q.size() != 0) begin
            check("out_data", out_data, sb_q[0]);
            if (out_ready) m_hold = sb_q.pop_front();
         end else begin
            check("out_data_idle", out_data, m_hold);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_key(input int idx, input logic [KEY_W-1:0] data);
      key_wr_valid = 1'b1;
      key_wr_idx   = IDX_W'(idx);
      key_wr_data  = data;
      tick();
      key_wr_valid = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] words [3];
      logic [DATA_W-1:0] lane_one;
      int k;
      bit acc;

      repeat (3) tick();
      rst = 1'b0;

      // Locked: nothing gets through.
      in_valid = 1'b1;
      in_data  = rand512();
      repeat (20) tick();
      in_valid = 1'b0;

      // Correct key passes data unmodified.
      out_ready = 1'b1;
      write_key(0, W0);
      check("s2_loading", DATA_W'(key_state), DATA_W'(1));
      write_key(1, W1);
      check("s2_unlocked", DATA_W'(key_state), DATA_W'(2));
      in_valid = 1'b1;
      in_data  = {64{8'hA5}};
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("s2_clean_data", out_data, {64{8'hA5}});
      check("s2_match", DATA_W'(key_match), DATA_W'(1));
      tick();

      // One flipped key bit shows up once per 128-bit lane.
      write_key(1, W1 ^ 64'h1);
      in_valid = 1'b1;
      in_data  = '0;
      tick();
      in_valid = 1'b0;
      lane_one = {4{128'h1}};
      @(negedge clk);
      check("s3_scrambled", out_data, lane_one);
      check("s3_nomatch", DATA_W'(key_match), DATA_W'(0));
      tick();
      write_key(1, W1);

      // Backpressure: one word held, the rest drain in order.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) words[i] = rand512();
      k = 0;
      for (int cyc = 0; cyc < 30 && k < 3; cyc++) begin
         if (cyc == 4) begin
            check("s4_held_count", DATA_W'(k), DATA_W'(1));
            out_ready = 1'b1;
         end
         in_valid = 1'b1;
         in_data  = words[k];
         @(negedge clk);
         acc = in_ready;
         tick();
         if (acc) k++;
      end
      in_valid = 1'b0;
      check("s4_all_accepted", DATA_W'(k), DATA_W'(3));
      repeat (3) tick();

      // Clear with data pending; same-cycle write is dropped.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = rand512();
      tick();
      in_valid     = 1'b0;
      key_clear    = 1'b1;
      key_wr_valid = 1'b1;
      key_wr_idx   = '0;
      key_wr_data  = W0;
      tick();
      key_clear    = 1'b0;
      key_wr_valid = 1'b0;
      @(negedge clk);
      check("s5_flush_valid", DATA_W'(out_valid), DATA_W'(0));
      check("s5_flush_data", out_data, '0);
      check("s5_clearing1", DATA_W'(key_state), DATA_W'(3));
      tick();
      @(negedge clk);
      check("s5_clearing2", DATA_W'(key_state), DATA_W'(3));
      tick();
      @(negedge clk);
      check("s5_locked", DATA_W'(key_state), DATA_W'(0));
      tick();

      // Reset while loading.
      write_key(0, W0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("s6_rst_state", DATA_W'(key_state), DATA_W'(0));
      check("s6_rst_ready", DATA_W'(key_wr_ready), DATA_W'(1));
      tick();

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         rst          = ($urandom_range(0, 299) == 0);
         key_clear    = ($urandom_range(0, 99) == 0);
         key_wr_valid = ($urandom_range(0, 5) == 0);
         key_wr_idx   = IDX_W'($urandom_range(0, 1));
         key_wr_data  = ($urandom_range(0, 3) != 0) ? (key_wr_idx[0] ? W1 : W0)
                                                    : {$urandom, $urandom};
         in_valid     = $urandom_range(0, 1) == 1;
         in_data      = rand512();
         out_ready    = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst          = 1'b0;
      key_clear    = 1'b0;
      key_wr_valid = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
